uart_csr_ctrl: RTL and testbench
================================

Name: uart_csr_ctrl

Overview:
Second-generation UART control/status register block sitting between the CPU bus controller and the UART Tx/Rx cores and their FIFOs. Unlike the first generation, it drives the Tx/Rx FIFOs directly:
- a CPU write to TXDATA pushes the Tx FIFO;
- a CPU read of RXDATA pops the Rx FIFO.

It also latches error and event status as sticky write-1-to-clear bits and auto-clears the Tx start bit. Register storage is internal; no separate register-file instance.

Parameters:
MAX_UART_DATA_W, 8, width of UART character / FIFO data (1..16)
BAUD_RATE_SEL_W, 2, baud select width (1..2)
TOTAL_CONF_W, 5, conf field width {data[1:0], stop[1:0], parity_en}; fixed at 5
CPU_ADDR_WIDTH, 3, word address width; map needs 6 words
CPU_DATA_WIDTH, 32, CPU data width (must be 32)

Ports:
clk_i  in  1  top clock
rst_ni  in  1  asynchronous active-low reset
tx_done_i, tx_busy_i  in  1 each  Tx core status (done = 1-cycle pulse)
rx_done_i, rx_busy_i, rx_parity_err_i, rx_stop_err_i  in  1 each  Rx core status (errors valid with rx_done_i)
tx_fifo_full_i, tx_fifo_nearly_full_i, tx_fifo_empty_i, tx_fifo_nearly_empty_i  in  1 each  Tx FIFO flags
rx_fifo_full_i, rx_fifo_nearly_full_i, rx_fifo_empty_i, rx_fifo_nearly_empty_i  in  1 each  Rx FIFO flags
rx_fifo_data_i  in  MAX_UART_DATA_W  Rx FIFO head (first-word-fall-through)
tx_fifo_push_o  out  1  Tx FIFO push, 1-cycle pulse
tx_fifo_data_o  out  MAX_UART_DATA_W  Tx FIFO write data
rx_fifo_pop_o  out  1  Rx FIFO pop, 1-cycle pulse
baud_sel_o  out  BAUD_RATE_SEL_W  baud select
tx_en_o, tx_start_o, tx_fifo_en_o, rx_en_o, rx_fifo_en_o  out  1 each  enables/start
tx_conf_o, rx_conf_o  out  TOTAL_CONF_W  Tx/Rx configuration
wr_en_cpu_i, rd_en_cpu_i  in  1 each  CPU write/read strobes
cpu_addr_i  in  CPU_ADDR_WIDTH  word address
cpu_data_i  in  32  write data
cpu_data_o  out  32  read data, registered
irq_o  out  1  level interrupt (see Optional Feature)

Behaviour:
Reset (rst_ni=0, asynchronous):
- All registers, sticky bits, cpu_data_o, push/pop and irq_o go to 0.
- All config outputs go to 0.

Register map (word address):
- 0 STAT: live bits
  - [1] tx_busy, [8..11] tx_fifo empty/nearly_empty/full/nearly_full
  - [17] rx_busy, [24..27] rx_fifo empty/nearly_empty/full/nearly_full
- 0 STAT: sticky W1C bits
  - [0] tx_done, [16] rx_done, [18] parity_err, [19] stop_err
  - [12] tx_ovf, [28] rx_udf, [29] rx_ovr
- 1 CTRL (RW): [0] tx_en, [1] tx_start, [6:2] tx_conf, [7] tx_fifo_en, [16] rx_en, [22:18] rx_conf, [23] rx_fifo_en, [31 -: BAUD_RATE_SEL_W] baud_sel. Unlisted bits read 0.
- 2 TXDATA (WO, reads 0).
- 3 RXDATA (RO).
- 4 IRQ_EN, 5 IRQ_STAT (see Optional Feature).
- 6, 7 read 0; writes ignored.

CPU access:
- Reads: cpu_data_o updates on the clock edge after rd_en_cpu_i (1-cycle latency) and holds until the next read.
- Simultaneous wr_en_cpu_i and rd_en_cpu_i: the write is performed and the read returns pre-write contents.

TXDATA write:
- Tx FIFO not full: tx_fifo_push_o=1 for exactly one cycle after the write; tx_fifo_data_o = cpu_data_i[MAX_UART_DATA_W-1:0], registered.
- Tx FIFO full: no push; tx_ovf set.

RXDATA read:
- Rx FIFO not empty: cpu_data_o = zero-extended rx_fifo_data_i sampled at the read cycle; rx_fifo_pop_o pulses one cycle after.
- Rx FIFO empty: returns 0, no pop, rx_udf set.

Sticky bits:
- tx_done is set by tx_done_i; rx_done is set by rx_done_i.
- parity_err/stop_err are set when rx_done_i & the respective error input.
- rx_ovr is set when rx_done_i & rx_fifo_full_i.
- Writing 1 clears a bit; writing 0 has no effect.
- Set and clear in the same cycle: set wins.

tx_start:
- Self-clears the cycle after tx_done_i.
- CPU write to CTRL coincident with tx_done_i: the CPU value wins.

Config outputs are driven directly from CTRL flops; zero combinational path from the CPU inputs.

Optional Feature:
Macro UART_CSR_IRQ_EN.

Defined:
- IRQ_EN (RW): [0] tx_done, [1] rx_done, [2] rx_err (parity|stop|ovr), [3] tx_fifo_empty, [4] rx_fifo_nearly_full.
- IRQ_STAT (W1C): bit n is set on the rising edge of its source while IRQ_EN[n]=1.
- irq_o = registered OR of IRQ_STAT, so it asserts one cycle after IRQ_STAT sets.

Undefined:
- Addresses 4 and 5 read 0; writes are ignored.
- irq_o is tied 0.

Test Plan:
- Reset: release rst_ni, read addr 0/1 -> CTRL=0x00000000, STAT bit pattern equals only live flag inputs (e.g. tx_fifo_empty_i=1 -> 0x00000100).
- Write CTRL=0xC005_0003, then tx_done_i pulse -> baud_sel_o=2'b11, rx_en_o=1, tx_en_o=1, tx_start_o=1 until tx_done_i, 0 the cycle after; STAT[0]=1 until W1C 0x1.
- Write TXDATA=0x1A5 with FIFO not full -> one push pulse, tx_fifo_data_o=0xA5; repeat with tx_fifo_full_i=1 -> no push, STAT[12]=1.
- rx_fifo_data_i=0x3C, empty=0, read RXDATA -> cpu_data_o=0x0000003C next cycle, one pop pulse; with empty=1 -> 0, no pop, STAT[28]=1.
- rx_done_i with rx_parity_err_i=1 and rx_fifo_full_i=1, same cycle as CPU W1C 0x000C0000 -> bits 18 and 29 remain 1 (set wins).
- UART_CSR_IRQ_EN: IRQ_EN=0x2, rx_done_i pulse -> IRQ_STAT=0x2, irq_o=1 next cycle; W1C 0x2 -> irq_o=0; without macro irq_o stays 0, addr 4 reads 0.

Source files
------------

// File: rtl/uart_csr_ctrl.sv
// uart_csr_ctrl: UART control/status registers driving the Tx/Rx FIFOs directly.
// Optional macro UART_CSR_IRQ_EN enables IRQ_EN/IRQ_STAT and irq_o. Rev 1.0
`default_nettype none

module uart_csr_ctrl #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int BAUD_RATE_SEL_W = 2,
  parameter int TOTAL_CONF_W    = 5,
  parameter int CPU_ADDR_WIDTH  = 3,
  parameter int CPU_DATA_WIDTH  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       tx_done_i,
  input  logic                       tx_busy_i,
  input  logic                       rx_done_i,
  input  logic                       rx_busy_i,
  input  logic                       rx_parity_err_i,
  input  logic                       rx_stop_err_i,
  input  logic                       tx_fifo_full_i,
  input  logic                       tx_fifo_nearly_full_i,
  input  logic                       tx_fifo_empty_i,
  input  logic                       tx_fifo_nearly_empty_i,
  input  logic                       rx_fifo_full_i,
  input  logic                       rx_fifo_nearly_full_i,
  input  logic                       rx_fifo_empty_i,
  input  logic                       rx_fifo_nearly_empty_i,
  input  logic [MAX_UART_DATA_W-1:0] rx_fifo_data_i,
  output logic                       tx_fifo_push_o,
  output logic [MAX_UART_DATA_W-1:0] tx_fifo_data_o,
  output logic                       rx_fifo_pop_o,
  output logic [BAUD_RATE_SEL_W-1:0] baud_sel_o,
  output logic                       tx_en_o,
  output logic                       tx_start_o,
  output logic                       tx_fifo_en_o,
  output logic                       rx_en_o,
  output logic                       rx_fifo_en_o,
  output logic [TOTAL_CONF_W-1:0]    tx_conf_o,
  output logic [TOTAL_CONF_W-1:0]    rx_conf_o,
  input  logic                       wr_en_cpu_i,
  input  logic                       rd_en_cpu_i,
  input  logic [CPU_ADDR_WIDTH-1:0]  cpu_addr_i,
  input  logic [CPU_DATA_WIDTH-1:0]  cpu_data_i,
  output logic [CPU_DATA_WIDTH-1:0]  cpu_data_o,
  output logic                       irq_o
);

  localparam logic [CPU_ADDR_WIDTH-1:0] c_ADDR_STAT   = CPU_ADDR_WIDTH'(0);
  localparam logic [CPU_ADDR_WIDTH-1:0] c_ADDR_CTRL   = CPU_ADDR_WIDTH'(1);
  localparam logic [CPU_ADDR_WIDTH-1:0] c_ADDR_TXDATA = CPU_ADDR_WIDTH'(2);
  localparam logic [CPU_ADDR_WIDTH-1:0] c_ADDR_RXDATA = CPU_ADDR_WIDTH'(3);
  localparam logic [CPU_ADDR_WIDTH-1:0] c_ADDR_IRQEN  = CPU_ADDR_WIDTH'(4);
  localparam logic [CPU_ADDR_WIDTH-1:0] c_ADDR_IRQST  = CPU_ADDR_WIDTH'(5);

  logic                       r_tx_en, r_tx_start, r_tx_fifo_en, r_rx_en, r_rx_fifo_en;
  logic [TOTAL_CONF_W-1:0]    r_tx_conf, r_rx_conf;
  logic [BAUD_RATE_SEL_W-1:0] r_baud;
  logic                       r_tx_done, r_rx_done, r_par_err, r_stop_err;
  logic                       r_tx_ovf, r_rx_udf, r_rx_ovr;
  logic                       r_push, r_pop;
  logic [MAX_UART_DATA_W-1:0] r_tx_data;
  logic [CPU_DATA_WIDTH-1:0]  r_rd_data;

  logic w_wr_stat, w_wr_ctrl, w_wr_tx, w_rd_rx;
  logic [CPU_DATA_WIDTH-1:0] w_stat, w_ctrl, w_rd_word;

  assign w_wr_stat = wr_en_cpu_i && (cpu_addr_i == c_ADDR_STAT);
  assign w_wr_ctrl = wr_en_cpu_i && (cpu_addr_i == c_ADDR_CTRL);
  assign w_wr_tx   = wr_en_cpu_i && (cpu_addr_i == c_ADDR_TXDATA);
  assign w_rd_rx   = rd_en_cpu_i && (cpu_addr_i == c_ADDR_RXDATA);

  always_comb begin
    w_stat     = '0;
    w_stat[0]  = r_tx_done;
    w_stat[1]  = tx_busy_i;
    w_stat[8]  = tx_fifo_empty_i;
    w_stat[9]  = tx_fifo_nearly_empty_i;
    w_stat[10] = tx_fifo_full_i;
    w_stat[11] = tx_fifo_nearly_full_i;
    w_stat[12] = r_tx_ovf;
    w_stat[16] = r_rx_done;
    w_stat[17] = rx_busy_i;
    w_stat[18] = r_par_err;
    w_stat[19] = r_stop_err;
    w_stat[24] = rx_fifo_empty_i;
    w_stat[25] = rx_fifo_nearly_empty_i;
    w_stat[26] = rx_fifo_full_i;
    w_stat[27] = rx_fifo_nearly_full_i;
    w_stat[28] = r_rx_udf;
    w_stat[29] = r_rx_ovr;
  end

  always_comb begin
    w_ctrl        = '0;
    w_ctrl[0]     = r_tx_en;
    w_ctrl[1]     = r_tx_start;
    w_ctrl[6:2]   = r_tx_conf;
    w_ctrl[7]     = r_tx_fifo_en;
    w_ctrl[16]    = r_rx_en;
    w_ctrl[22:18] = r_rx_conf;
    w_ctrl[23]    = r_rx_fifo_en;
    w_ctrl[31 -: BAUD_RATE_SEL_W] = r_baud;
  end

`ifdef UART_CSR_IRQ_EN
  logic [4:0] r_irq_en, r_irq_stat, r_src_q;
  logic       r_irq;
  logic [4:0] w_src, w_irq_set, w_irq_clr;

  assign w_src = {rx_fifo_nearly_full_i, tx_fifo_empty_i,
                  rx_done_i & (rx_parity_err_i | rx_stop_err_i | rx_fifo_full_i),
                  rx_done_i, tx_done_i};
  assign w_irq_set = w_src & ~r_src_q & r_irq_en;
  assign w_irq_clr = (wr_en_cpu_i && (cpu_addr_i == c_ADDR_IRQST)) ? cpu_data_i[4:0] : 5'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_src_q    <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (wr_en_cpu_i && (cpu_addr_i == c_ADDR_IRQEN)) r_irq_en <= cpu_data_i[4:0];
      r_irq_stat <= w_irq_set | (r_irq_stat & ~w_irq_clr);
      r_src_q    <= w_src;
      r_irq      <= |r_irq_stat;
    end
  end

  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    w_rd_word = '0;
    case (cpu_addr_i)
      c_ADDR_STAT:   w_rd_word = w_stat;
      c_ADDR_CTRL:   w_rd_word = w_ctrl;
      c_ADDR_RXDATA: if (!rx_fifo_empty_i)
                       w_rd_word = {{(CPU_DATA_WIDTH-MAX_UART_DATA_W){1'b0}}, rx_fifo_data_i};
`ifdef UART_CSR_IRQ_EN
      c_ADDR_IRQEN:  w_rd_word = {27'd0, r_irq_en};
      c_ADDR_IRQST:  w_rd_word = {27'd0, r_irq_stat};
`endif
      default:       w_rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_en      <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_conf    <= '0;
      r_tx_fifo_en <= 1'b0;
      r_rx_en      <= 1'b0;
      r_rx_conf    <= '0;
      r_rx_fifo_en <= 1'b0;
      r_baud       <= '0;
    end else if (w_wr_ctrl) begin
      r_tx_en      <= cpu_data_i[0];
      r_tx_start   <= cpu_data_i[1];
      r_tx_conf    <= cpu_data_i[6:2];
      r_tx_fifo_en <= cpu_data_i[7];
      r_rx_en      <= cpu_data_i[16];
      r_rx_conf    <= cpu_data_i[22:18];
      r_rx_fifo_en <= cpu_data_i[23];
      r_baud       <= cpu_data_i[31 -: BAUD_RATE_SEL_W];
    end else if (tx_done_i) begin
      r_tx_start   <= 1'b0;
    end
  end

  // Sticky status: a set in the same cycle as a write-1-clear takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_done  <= 1'b0;
      r_rx_done  <= 1'b0;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_rx_udf   <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      r_tx_done  <= tx_done_i | (r_tx_done & ~(w_wr_stat & cpu_data_i[0]));
      r_rx_done  <= rx_done_i | (r_rx_done & ~(w_wr_stat & cpu_data_i[16]));
      r_par_err  <= (rx_done_i & rx_parity_err_i) | (r_par_err & ~(w_wr_stat & cpu_data_i[18]));
      r_stop_err <= (rx_done_i & rx_stop_err_i) | (r_stop_err & ~(w_wr_stat & cpu_data_i[19]));
      r_tx_ovf   <= (w_wr_tx & tx_fifo_full_i) | (r_tx_ovf & ~(w_wr_stat & cpu_data_i[12]));
      r_rx_udf   <= (w_rd_rx & rx_fifo_empty_i) | (r_rx_udf & ~(w_wr_stat & cpu_data_i[28]));
      r_rx_ovr   <= (rx_done_i & rx_fifo_full_i) | (r_rx_ovr & ~(w_wr_stat & cpu_data_i[29]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_push    <= 1'b0;
      r_pop     <= 1'b0;
      r_tx_data <= '0;
      r_rd_data <= '0;
    end else begin
      r_push <= w_wr_tx & ~tx_fifo_full_i;
      r_pop  <= w_rd_rx & ~rx_fifo_empty_i;
      if (w_wr_tx && !tx_fifo_full_i) r_tx_data <= cpu_data_i[MAX_UART_DATA_W-1:0];
      if (rd_en_cpu_i) r_rd_data <= w_rd_word;
    end
  end

  logic w_unused;
  assign w_unused = ^cpu_data_i;

  assign tx_fifo_push_o = r_push;
  assign tx_fifo_data_o = r_tx_data;
  assign rx_fifo_pop_o  = r_pop;
  assign cpu_data_o     = r_rd_data;
  assign baud_sel_o     = r_baud;
  assign tx_en_o        = r_tx_en;
  assign tx_start_o     = r_tx_start;
  assign tx_fifo_en_o   = r_tx_fifo_en;
  assign rx_en_o        = r_rx_en;
  assign rx_fifo_en_o   = r_rx_fifo_en;
  assign tx_conf_o      = r_tx_conf;
  assign rx_conf_o      = r_rx_conf;

endmodule

`default_nettype wire

// File: tb/tb_uart_csr_ctrl.sv
// tb_uart_csr_ctrl: directed self-checking bench for uart_csr_ctrl. Rev 1.0
`default_nettype none

module tb_uart_csr_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        tx_done_i = 0, tx_busy_i = 0, rx_done_i = 0, rx_busy_i = 0;
  logic        rx_parity_err_i = 0, rx_stop_err_i = 0;
  logic        tx_fifo_full_i = 0, tx_fifo_nearly_full_i = 0, tx_fifo_empty_i = 1, tx_fifo_nearly_empty_i = 0;
  logic        rx_fifo_full_i = 0, rx_fifo_nearly_full_i = 0, rx_fifo_empty_i = 0, rx_fifo_nearly_empty_i = 0;
  logic [7:0]  rx_fifo_data_i = 8'h00;
  logic        tx_fifo_push_o, rx_fifo_pop_o;
  logic [7:0]  tx_fifo_data_o;
  logic [1:0]  baud_sel_o;
  logic        tx_en_o, tx_start_o, tx_fifo_en_o, rx_en_o, rx_fifo_en_o;
  logic [4:0]  tx_conf_o, rx_conf_o;
  logic        wr_en_cpu_i = 0, rd_en_cpu_i = 0;
  logic [2:0]  cpu_addr_i = 3'd0;
  logic [31:0] cpu_data_i = 32'd0;
  logic [31:0] cpu_data_o;
  logic        irq_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  uart_csr_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tx_done_i(tx_done_i), .tx_busy_i(tx_busy_i),
    .rx_done_i(rx_done_i), .rx_busy_i(rx_busy_i),
    .rx_parity_err_i(rx_parity_err_i), .rx_stop_err_i(rx_stop_err_i),
    .tx_fifo_full_i(tx_fifo_full_i), .tx_fifo_nearly_full_i(tx_fifo_nearly_full_i),
    .tx_fifo_empty_i(tx_fifo_empty_i), .tx_fifo_nearly_empty_i(tx_fifo_nearly_empty_i),
    .rx_fifo_full_i(rx_fifo_full_i), .rx_fifo_nearly_full_i(rx_fifo_nearly_full_i),
    .rx_fifo_empty_i(rx_fifo_empty_i), .rx_fifo_nearly_empty_i(rx_fifo_nearly_empty_i),
    .rx_fifo_data_i(rx_fifo_data_i),
    .tx_fifo_push_o(tx_fifo_push_o), .tx_fifo_data_o(tx_fifo_data_o),
    .rx_fifo_pop_o(rx_fifo_pop_o), .baud_sel_o(baud_sel_o),
    .tx_en_o(tx_en_o), .tx_start_o(tx_start_o), .tx_fifo_en_o(tx_fifo_en_o),
    .rx_en_o(rx_en_o), .rx_fifo_en_o(rx_fifo_en_o),
    .tx_conf_o(tx_conf_o), .rx_conf_o(rx_conf_o),
    .wr_en_cpu_i(wr_en_cpu_i), .rd_en_cpu_i(rd_en_cpu_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .irq_o(irq_o)
  );

  // Inputs change on negedge; outputs are observed on the following negedge.
  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk_i);
    wr_en_cpu_i = 1; cpu_addr_i = a; cpu_data_i = d;
    @(negedge clk_i);
    wr_en_cpu_i = 0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk_i);
    rd_en_cpu_i = 1; cpu_addr_i = a;
    @(negedge clk_i);
    rd_en_cpu_i = 0;
    d = cpu_data_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #12;
    checks++;
    if ({tx_fifo_push_o, rx_fifo_pop_o, tx_start_o, tx_en_o, rx_en_o, irq_o} !== 6'b0 || cpu_data_o !== 32'h0 || baud_sel_o !== 2'b00) begin
      failures++; $display("FAIL reset_outputs push=%b pop=%b start=%b data=%h baud=%b", tx_fifo_push_o, rx_fifo_pop_o, tx_start_o, cpu_data_o, baud_sel_o);
    end
    @(negedge clk_i); rst_ni = 1;
    cpu_read(3'd0, d);
    checks++;
    if (d !== 32'h0000_0100) begin failures++; $display("FAIL reset_stat got=%h exp=%h", d, 32'h0000_0100); end
    cpu_read(3'd1, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    cpu_read(3'd6, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL addr6_read got=%h exp=0", d); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d;
    cpu_write(3'd1, 32'hFFFF_FFFF);
    cpu_read(3'd1, d);
    checks++;
    if (d !== 32'hC0FD_00FF) begin failures++; $display("FAIL ctrl_mask got=%h exp=%h", d, 32'hC0FD_00FF); end
    cpu_write(3'd1, 32'hC005_0003);
    checks++;
    if (baud_sel_o !== 2'b11 || rx_en_o !== 1'b1 || tx_en_o !== 1'b1 || tx_start_o !== 1'b1 ||
        rx_conf_o !== 5'b00001 || tx_conf_o !== 5'b0 || tx_fifo_en_o !== 1'b0 || rx_fifo_en_o !== 1'b0) begin
      failures++; $display("FAIL ctrl_outputs baud=%b rx_en=%b tx_en=%b start=%b rx_conf=%b tx_conf=%b", baud_sel_o, rx_en_o, tx_en_o, tx_start_o, rx_conf_o, tx_conf_o);
    end
    cpu_read(3'd1, d);
    checks++;
    if (d !== 32'hC005_0003) begin failures++; $display("FAIL ctrl_readback got=%h exp=%h", d, 32'hC005_0003); end
    @(negedge clk_i); tx_done_i = 1;
    @(negedge clk_i); tx_done_i = 0;
    checks++;
    if (tx_start_o !== 1'b0) begin failures++; $display("FAIL tx_start_autoclear got=%b exp=0", tx_start_o); end
    cpu_read(3'd0, d);
    checks++;
    if (d !== 32'h0000_0101) begin failures++; $display("FAIL stat_tx_done got=%h exp=%h", d, 32'h0000_0101); end
    cpu_write(3'd0, 32'h0000_0001);
    cpu_read(3'd0, d);
    checks++;
    if (d !== 32'h0000_0100) begin failures++; $display("FAIL stat_tx_done_w1c got=%h exp=%h", d, 32'h0000_0100); end
    // CTRL write coincident with tx_done: CPU value must win.
    @(negedge clk_i); wr_en_cpu_i = 1; cpu_addr_i = 3'd1; cpu_data_i = 32'hC005_0003; tx_done_i = 1;
    @(negedge clk_i); wr_en_cpu_i = 0; tx_done_i = 0;
    checks++;
    if (tx_start_o !== 1'b1) begin failures++; $display("FAIL tx_start_cpu_wins got=%b exp=1", tx_start_o); end
    cpu_write(3'd0, 32'h0000_0001);
  endtask

  task automatic test_txdata();
    logic [31:0] d;
    tx_fifo_empty_i = 0;
    @(negedge clk_i); wr_en_cpu_i = 1; cpu_addr_i = 3'd2; cpu_data_i = 32'h0000_01A5;
    @(negedge clk_i); wr_en_cpu_i = 0;
    checks++;
    if (tx_fifo_push_o !== 1'b1 || tx_fifo_data_o !== 8'hA5) begin failures++; $display("FAIL tx_push got=%b/%h exp=1/a5", tx_fifo_push_o, tx_fifo_data_o); end
    @(negedge clk_i);
    checks++;
    if (tx_fifo_push_o !== 1'b0) begin failures++; $display("FAIL tx_push_width got=%b exp=0", tx_fifo_push_o); end
    cpu_read(3'd2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL txdata_read got=%h exp=0", d); end
    tx_fifo_full_i = 1;
    @(negedge clk_i); wr_en_cpu_i = 1; cpu_addr_i = 3'd2; cpu_data_i = 32'h0000_005A;
    @(negedge clk_i); wr_en_cpu_i = 0;
    checks++;
    if (tx_fifo_push_o !== 1'b0 || tx_fifo_data_o !== 8'hA5) begin failures++; $display("FAIL tx_full_nopush got=%b/%h exp=0/a5", tx_fifo_push_o, tx_fifo_data_o); end
    cpu_read(3'd0, d);
    checks++;
    if (d !== 32'h0000_1400) begin failures++; $display("FAIL stat_tx_ovf got=%h exp=%h", d, 32'h0000_1400); end
    tx_fifo_full_i = 0;
    cpu_write(3'd0, 32'h0000_1000);
  endtask

  task automatic test_rxdata();
    logic [31:0] d;
    rx_fifo_data_i = 8'h3C; rx_fifo_empty_i = 0;
    @(negedge clk_i); rd_en_cpu_i = 1; cpu_addr_i = 3'd3;
    @(negedge clk_i); rd_en_cpu_i = 0; rx_fifo_data_i = 8'h77;
    checks++;
    if (cpu_data_o !== 32'h0000_003C || rx_fifo_pop_o !== 1'b1) begin failures++; $display("FAIL rx_read got=%h pop=%b exp=0000003c pop=1", cpu_data_o, rx_fifo_pop_o); end
    @(negedge clk_i);
    checks++;
    if (rx_fifo_pop_o !== 1'b0 || cpu_data_o !== 32'h0000_003C) begin failures++; $display("FAIL rx_pop_hold pop=%b data=%h exp=0/0000003c", rx_fifo_pop_o, cpu_data_o); end
    rx_fifo_empty_i = 1;
    @(negedge clk_i); rd_en_cpu_i = 1; cpu_addr_i = 3'd3;
    @(negedge clk_i); rd_en_cpu_i = 0;
    checks++;
    if (cpu_data_o !== 32'h0 || rx_fifo_pop_o !== 1'b0) begin failures++; $display("FAIL rx_empty_read got=%h pop=%b exp=0/0", cpu_data_o, rx_fifo_pop_o); end
    cpu_read(3'd0, d);
    checks++;
    if (d !== 32'h1100_0000) begin failures++; $display("FAIL stat_rx_udf got=%h exp=%h", d, 32'h1100_0000); end
    cpu_write(3'd0, 32'h1000_0000);
  endtask

  task automatic test_sticky_set_wins();
    logic [31:0] d;
    @(negedge clk_i);
    rx_done_i = 1; rx_parity_err_i = 1; rx_fifo_full_i = 1;
    wr_en_cpu_i = 1; cpu_addr_i = 3'd0; cpu_data_i = 32'h000C_0000;
    @(negedge clk_i);
    rx_done_i = 0; rx_parity_err_i = 0; rx_fifo_full_i = 0; wr_en_cpu_i = 0;
    cpu_read(3'd0, d);
    checks++;
    if (d !== 32'h2105_0000) begin failures++; $display("FAIL sticky_set_wins got=%h exp=%h", d, 32'h2105_0000); end
    @(negedge clk_i); rx_done_i = 1; rx_stop_err_i = 1;
    @(negedge clk_i); rx_done_i = 0; rx_stop_err_i = 0;
    cpu_read(3'd0, d);
    checks++;
    if (d !== 32'h210D_0000) begin failures++; $display("FAIL sticky_stop_err got=%h exp=%h", d, 32'h210D_0000); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    // Same-cycle write and read: read returns pre-write contents.
    @(negedge clk_i); wr_en_cpu_i = 1; rd_en_cpu_i = 1; cpu_addr_i = 3'd0; cpu_data_i = 32'hFFFF_FFFF;
    @(negedge clk_i); wr_en_cpu_i = 0; rd_en_cpu_i = 0;
    checks++;
    if (cpu_data_o !== 32'h210D_0000) begin failures++; $display("FAIL rw_same_cycle got=%h exp=%h", cpu_data_o, 32'h210D_0000); end
    cpu_read(3'd0, d);
    checks++;
    if (d !== 32'h0100_0000) begin failures++; $display("FAIL w1c_all got=%h exp=%h", d, 32'h0100_0000); end
    cpu_write(3'd7, 32'hFFFF_FFFF);
    cpu_read(3'd7, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL addr7_read got=%h exp=0", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
`ifdef UART_CSR_IRQ_EN
    cpu_write(3'd4, 32'h0000_0002);
    cpu_read(3'd4, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL irq_en_read got=%h exp=2", d); end
    @(negedge clk_i); rx_done_i = 1;
    @(negedge clk_i); rx_done_i = 0;
    checks++;
    if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_latency got=%b exp=0", irq_o); end
    @(negedge clk_i);
    checks++;
    if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_assert got=%b exp=1", irq_o); end
    cpu_read(3'd5, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL irq_stat got=%h exp=2", d); end
    cpu_write(3'd5, 32'h0000_0002);
    @(negedge clk_i);
    checks++;
    if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq_o); end
`else
    cpu_write(3'd4, 32'h0000_001F);
    cpu_read(3'd4, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL addr4_read got=%h exp=0", d); end
    @(negedge clk_i); rx_done_i = 1;
    @(negedge clk_i); rx_done_i = 0;
    @(negedge clk_i);
    checks++;
    if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_tied got=%b exp=0", irq_o); end
    cpu_read(3'd5, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL addr5_read got=%h exp=0", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_txdata();
    test_rxdata();
    test_sticky_set_wins();
    test_back_to_back();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
